lfsr_mult_driver: RTL and testbench
===================================

Name: lfsr_mult_driver

Overview:
- Upstream operand source and result collector for the 16-bit shift-add multiplier.
- A Galois LFSR generates operand pairs (m, n) for each operation.
- Each pair is issued over the multiplier's start/busy handshake; the returned product is captured and folded into a MISR signature.
- Used for self-test runs of N multiplications, with a watchdog on the handshake.

Parameters:
- WIDTH, 16: operand, product, LFSR and signature width.
- SEED, 16'hACE1: LFSR reset value; also substituted whenever a zero seed is loaded.
- POLY, 16'hB400: Galois feedback mask (right-shift form).
- COUNT_W, 8: width of the operation counter.
- TIMEOUT, 255: watchdog limit in cycles per handshake phase.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- go  in  1  start-of-run pulse; sampled only in IDLE.
- num_ops  in  COUNT_W  operations per run; latched when go is accepted.
- seed_load  in  1  load seed_in into the LFSR; IDLE only.
- seed_in  in  WIDTH  new LFSR seed.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- m_out  out  WIDTH  operand m to the multiplier.
- n_out  out  WIDTH  operand n to the multiplier.
- mult_prod  in  WIDTH  multiplier product.
- mult_busy  in  1  multiplier busy flag.
- run_busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at run end (normal or aborted).
- err_timeout  out  1  sticky watchdog error; cleared by the next accepted go.
- last_prod  out  WIDTH  most recently captured product.
- signature  out  WIDTH  MISR value.
- op_count  out  COUNT_W  operations completed in the current or last run.

Behaviour:
- Reset (async, any state): state=IDLE, lfsr=SEED, m_out=n_out=0, last_prod=0, signature=0, op_count=0, mult_start=0, done=0, err_timeout=0, run_busy=0. All outputs are registered, so mult_start drops immediately on reset.
- step(x) = (x>>1) ^ (x[0] ? POLY : 0). The LFSR never holds 0; a zero seed_in loads SEED instead.
- States: IDLE, GEN_M, GEN_N, ISSUE, WAIT_HI, WAIT_LO, CAPTURE, DONE.
- IDLE:
  - seed_load=1: lfsr<=seed_in. seed_load has priority; go in the same cycle is ignored.
  - go=1 with num_ops!=0: latch num_ops, clear signature/op_count/err_timeout, go to GEN_M.
  - go=1 with num_ops==0: done pulses next cycle, stay IDLE, no other state change.
- GEN_M: m_out<=lfsr, lfsr<=step(lfsr); go to GEN_N.
- GEN_N: n_out<=lfsr, lfsr<=step(lfsr); go to ISSUE.
- ISSUE: mult_start=1 for exactly this cycle; timer<=0; go to WAIT_HI. m_out/n_out stay stable from ISSUE until the next GEN_M.
- WAIT_HI (waiting for busy to rise):
  - mult_busy=1: timer<=0, go to WAIT_LO.
  - Otherwise timer++; when timer==TIMEOUT-1, abort.
- WAIT_LO (waiting for busy to fall):
  - mult_busy=0: go to CAPTURE.
  - Otherwise timer++; when timer==TIMEOUT-1, abort.
- CAPTURE: last_prod<=mult_prod, signature<=step(signature)^mult_prod, op_count++. If the new op_count==latched num_ops go to DONE, else GEN_M.
- DONE: done=1 for one cycle; go to IDLE.
- Abort: err_timeout<=1, go to DONE. op_count and signature keep partial values; the LFSR is not rewound.
- go and seed_load are ignored while run_busy=1.
- Latency: mult_start is high in the 3rd cycle after go is sampled. Per-op overhead beyond multiplier busy time is 5 cycles (GEN_M, GEN_N, ISSUE, WAIT_HI minimum, CAPTURE).
- op_count uses COUNT_W-bit modular arithmetic. num_ops=2^COUNT_W-1 runs the full count with no wrap before DONE.

Test Plan:
- Default seed, go with num_ops=1, behavioural multiplier returning the low 16 bits of m*n -> m_out=0xACE1, n_out=0xE270, exactly one mult_start pulse, last_prod=0x4470, signature=0x4470, op_count=1, done one cycle, lfsr=0x7138.
- seed_load with seed_in=0x0000, then go with num_ops=1 -> m_out=0xACE1 (zero replaced by SEED). Repeat with seed_in=0x0001 -> m_out=0x0001, n_out=0xB400.
- go with num_ops=4, multiplier busy for 3-20 random cycles -> exactly 4 mult_start pulses, op_count=4, signature matches the reference model, run_busy low after done.
- mult_busy held 0 after mult_start -> err_timeout=1 and done pulse TIMEOUT cycles later. The next go clears err_timeout.
- Async rst asserted in WAIT_LO mid-run -> all outputs at reset values in the same cycle. A subsequent go restarts from m_out=0xACE1.
- go with num_ops=0 -> done the next cycle, no mult_start, signature unchanged. go asserted during a run -> ignored, run length unaffected.

Source files
------------

// File: rtl/lfsr_mult_driver.sv
// Self-test driver for the shift-add multiplier: LFSR operand generation,
// start/busy handshake with watchdog, and MISR folding of returned products.
module lfsr_mult_driver #(
    parameter int               WIDTH   = 16,
    parameter logic [WIDTH-1:0] SEED    = 16'hACE1,
    parameter logic [WIDTH-1:0] POLY    = 16'hB400,
    parameter int               COUNT_W = 8,
    parameter int               TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [COUNT_W-1:0] num_ops,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed_in,
    output logic               mult_start,
    output logic [WIDTH-1:0]   m_out,
    output logic [WIDTH-1:0]   n_out,
    input  logic [WIDTH-1:0]   mult_prod,
    input  logic               mult_busy,
    output logic               run_busy,
    output logic               done,
    output logic               err_timeout,
    output logic [WIDTH-1:0]   last_prod,
    output logic [WIDTH-1:0]   signature,
    output logic [COUNT_W-1:0] op_count
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, GEN_M, GEN_N, ISSUE, WAIT_HI, WAIT_LO, CAPTURE, DONE
    } state_t;

    state_t             state, next_state;
    logic [WIDTH-1:0]   lfsr;
    logic [COUNT_W-1:0] num_ops_q;
    logic [COUNT_W-1:0] op_count_inc;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_inc;
    logic               timer_expired;
    logic               accept_go;
    logic               start_d, done_d, busy_d, abort_d;

    // Galois step in right-shift form; shared by the LFSR and the MISR.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
        return (x >> 1) ^ (x[0] ? POLY : '0);
    endfunction

    assign timer_inc     = timer + TIMER_W'(1);
    assign timer_expired = (timer_inc == TIMER_W'(TIMEOUT - 1));
    assign op_count_inc  = op_count + COUNT_W'(1);
    assign accept_go     = (state == IDLE) && !seed_load && go;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept_go && num_ops != '0) next_state = GEN_M;
            GEN_M:   next_state = GEN_N;
            GEN_N:   next_state = ISSUE;
            ISSUE:   next_state = WAIT_HI;
            WAIT_HI: begin
                if (mult_busy)          next_state = WAIT_LO;
                else if (timer_expired) next_state = DONE;
            end
            WAIT_LO: begin
                if (!mult_busy)         next_state = CAPTURE;
                else if (timer_expired) next_state = DONE;
            end
            CAPTURE: next_state = (op_count_inc == num_ops_q) ? DONE : GEN_M;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered control outputs, derived from the transition.
    always_comb begin
        start_d = (next_state == ISSUE);
        busy_d  = (next_state != IDLE);
        done_d  = (next_state == DONE) || (accept_go && num_ops == '0);
        abort_d = ((state == WAIT_HI) && !mult_busy && timer_expired) ||
                  ((state == WAIT_LO) &&  mult_busy && timer_expired);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr        <= SEED;
            m_out       <= '0;
            n_out       <= '0;
            last_prod   <= '0;
            signature   <= '0;
            op_count    <= '0;
            num_ops_q   <= '0;
            timer       <= '0;
            mult_start  <= 1'b0;
            done        <= 1'b0;
            run_busy    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            mult_start <= start_d;
            done       <= done_d;
            run_busy   <= busy_d;
            if (abort_d) err_timeout <= 1'b1;
            case (state)
                IDLE: begin
                    if (seed_load) begin
                        lfsr <= (seed_in == '0) ? SEED : seed_in;
                    end else if (go && num_ops != '0) begin
                        num_ops_q   <= num_ops;
                        signature   <= '0;
                        op_count    <= '0;
                        err_timeout <= 1'b0;
                    end
                end
                GEN_M: begin
                    m_out <= lfsr;
                    lfsr  <= step(lfsr);
                end
                GEN_N: begin
                    n_out <= lfsr;
                    lfsr  <= step(lfsr);
                end
                ISSUE:   timer <= '0;
                WAIT_HI: timer <= mult_busy ? '0 : timer_inc;
                WAIT_LO: timer <= timer_inc;
                CAPTURE: begin
                    last_prod <= mult_prod;
                    signature <= step(signature) ^ mult_prod;
                    op_count  <= op_count_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_mult_driver.sv
// Directed bench for lfsr_mult_driver with a behavioural multiplier responder.
module tb_lfsr_mult_driver;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [7:0]  num_ops;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        mult_start;
    logic [15:0] m_out, n_out;
    logic [15:0] mult_prod;
    logic        mult_busy;
    logic        run_busy, done, err_timeout;
    logic [15:0] last_prod, signature;
    logic [7:0]  op_count;

    int vectors = 0;
    int miscompares = 0;
    int start_cnt = 0;

    logic        stall_mode = 1'b0;
    logic        rand_busy = 1'b0;
    int          busy_len = 4;
    int          bcnt;

    logic [15:0] ref_lfsr, exp_m, exp_n, exp_prod, exp_sig;

    lfsr_mult_driver #(
        .WIDTH(16), .SEED(16'hACE1), .POLY(16'hB400), .COUNT_W(8), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .num_ops(num_ops),
        .seed_load(seed_load), .seed_in(seed_in),
        .mult_start(mult_start), .m_out(m_out), .n_out(n_out),
        .mult_prod(mult_prod), .mult_busy(mult_busy),
        .run_busy(run_busy), .done(done), .err_timeout(err_timeout),
        .last_prod(last_prod), .signature(signature), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier: busy rises the cycle after start, product valid at busy fall.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mult_busy <= 1'b0;
            mult_prod <= 16'h0000;
            bcnt      <= 0;
        end else if (mult_start && !stall_mode) begin
            mult_busy <= 1'b1;
            mult_prod <= m_out * n_out;
            bcnt      <= rand_busy ? int'($urandom_range(20, 3)) : busy_len;
        end else if (mult_busy) begin
            if (bcnt <= 1) mult_busy <= 1'b0;
            else           bcnt <= bcnt - 1;
        end
    end

    always @(negedge clk) if (mult_start) start_cnt <= start_cnt + 1;

    function automatic logic [15:0] step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_run(input int nops);
        exp_sig = 16'h0000;
        for (int i = 0; i < nops; i++) begin
            exp_m = ref_lfsr; ref_lfsr = step(ref_lfsr);
            exp_n = ref_lfsr; ref_lfsr = step(ref_lfsr);
            exp_prod = exp_m * exp_n;
            exp_sig = step(exp_sig) ^ exp_prod;
        end
    endtask

    // Starts a run from IDLE and returns at the negedge where done is seen.
    task automatic do_run(input logic [7:0] nops, output bit ok);
        @(negedge clk); go = 1'b1; num_ops = nops;
        @(negedge clk); go = 1'b0;
        ok = 1'b0;
        for (int b = 0; b < 5000; b++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; go = 1'b0; num_ops = 8'd0; seed_load = 1'b0; seed_in = 16'h0000;
        repeat (3) @(negedge clk);
        vectors++; if ({mult_start, done, run_busy, err_timeout} !== 4'b0000) begin miscompares++; $display("FAIL reset_ctrl: got %b want 0000", {mult_start, done, run_busy, err_timeout}); end
        vectors++; if ({m_out, n_out, last_prod, signature, op_count} !== 72'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", {m_out, n_out, last_prod, signature, op_count}); end
        rst = 1'b0;
        ref_lfsr = 16'hACE1;
    endtask

    task automatic test_single_op;
        bit ok; int s0;
        s0 = start_cnt;
        do_run(8'd1, ok);
        model_run(1);
        vectors++; if (!ok) begin miscompares++; $display("FAIL single_done: no done within budget"); end
        vectors++; if (m_out !== 16'hACE1) begin miscompares++; $display("FAIL single_m: got %h want ace1", m_out); end
        vectors++; if (n_out !== 16'hE270) begin miscompares++; $display("FAIL single_n: got %h want e270", n_out); end
        vectors++; if (last_prod !== 16'h4470) begin miscompares++; $display("FAIL single_prod: got %h want 4470", last_prod); end
        vectors++; if (signature !== 16'h4470) begin miscompares++; $display("FAIL single_sig: got %h want 4470", signature); end
        vectors++; if (op_count !== 8'd1) begin miscompares++; $display("FAIL single_count: got %0d want 1", op_count); end
        @(negedge clk);
        vectors++; if (done !== 1'b0 || run_busy !== 1'b0) begin miscompares++; $display("FAIL single_done_width: done=%b run_busy=%b want 0 0", done, run_busy); end
        vectors++; if (start_cnt - s0 !== 1) begin miscompares++; $display("FAIL single_starts: got %0d want 1", start_cnt - s0); end
        // The LFSR continues from where the previous run left it.
        do_run(8'd1, ok);
        model_run(1);
        vectors++; if (m_out !== 16'h7138) begin miscompares++; $display("FAIL continue_m: got %h want 7138", m_out); end
        vectors++; if (n_out !== exp_n) begin miscompares++; $display("FAIL continue_n: got %h want %h", n_out, exp_n); end
    endtask

    task automatic test_seed_load;
        bit ok;
        @(negedge clk); @(negedge clk);
        seed_load = 1'b1; seed_in = 16'h0000; go = 1'b1; num_ops = 8'd1;
        @(negedge clk); seed_load = 1'b0; go = 1'b0;
        @(negedge clk);
        vectors++; if (run_busy !== 1'b0) begin miscompares++; $display("FAIL seed_priority: run_busy=%b want 0", run_busy); end
        ref_lfsr = 16'hACE1;
        do_run(8'd1, ok);
        vectors++; if (m_out !== 16'hACE1) begin miscompares++; $display("FAIL seed_zero_m: got %h want ace1", m_out); end
        @(negedge clk);
        seed_load = 1'b1; seed_in = 16'h0001;
        @(negedge clk); seed_load = 1'b0;
        do_run(8'd1, ok);
        vectors++; if (m_out !== 16'h0001) begin miscompares++; $display("FAIL seed_one_m: got %h want 0001", m_out); end
        vectors++; if (n_out !== 16'hB400) begin miscompares++; $display("FAIL seed_one_n: got %h want b400", n_out); end
        vectors++; if (last_prod !== 16'hB400) begin miscompares++; $display("FAIL seed_one_prod: got %h want b400", last_prod); end
        ref_lfsr = 16'h0001;
        model_run(1);
    endtask

    task automatic test_multi_op;
        bit ok; int s0;
        @(negedge clk);
        rand_busy = 1'b1; s0 = start_cnt;
        do_run(8'd4, ok);
        model_run(4);
        vectors++; if (!ok) begin miscompares++; $display("FAIL multi_done: no done within budget"); end
        vectors++; if (op_count !== 8'd4) begin miscompares++; $display("FAIL multi_count: got %0d want 4", op_count); end
        vectors++; if (signature !== exp_sig) begin miscompares++; $display("FAIL multi_sig: got %h want %h", signature, exp_sig); end
        vectors++; if (last_prod !== exp_prod) begin miscompares++; $display("FAIL multi_prod: got %h want %h", last_prod, exp_prod); end
        @(negedge clk);
        vectors++; if (run_busy !== 1'b0) begin miscompares++; $display("FAIL multi_idle: run_busy=%b want 0", run_busy); end
        vectors++; if (start_cnt - s0 !== 4) begin miscompares++; $display("FAIL multi_starts: got %0d want 4", start_cnt - s0); end
        rand_busy = 1'b0;
    endtask

    task automatic test_timeout;
        bit ok, seen; int s0, cyc;
        @(negedge clk);
        stall_mode = 1'b1; s0 = start_cnt;
        go = 1'b1; num_ops = 8'd2;
        @(negedge clk); go = 1'b0;
        seen = 1'b0;
        for (int b = 0; b < 20; b++) begin
            if (mult_start) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        cyc = 0;
        for (int b = 0; b < 1000 && seen; b++) begin
            @(negedge clk); cyc++;
            if (done) break;
        end
        vectors++; if (cyc !== TIMEOUT) begin miscompares++; $display("FAIL timeout_latency: got %0d want %0d", cyc, TIMEOUT); end
        vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %b want 1", err_timeout); end
        vectors++; if (op_count !== 8'd0) begin miscompares++; $display("FAIL timeout_count: got %0d want 0", op_count); end
        @(negedge clk);
        vectors++; if (start_cnt - s0 !== 1 || run_busy !== 1'b0) begin miscompares++; $display("FAIL timeout_abort: starts=%0d run_busy=%b want 1 0", start_cnt - s0, run_busy); end
        ref_lfsr = step(step(ref_lfsr));
        stall_mode = 1'b0;
        go = 1'b1; num_ops = 8'd1;
        @(negedge clk); go = 1'b0;
        vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_clear: got %b want 0", err_timeout); end
        ok = 1'b0;
        for (int b = 0; b < 200; b++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        model_run(1);
        vectors++; if (!ok || m_out !== exp_m) begin miscompares++; $display("FAIL timeout_next_m: got %h want %h", m_out, exp_m); end
    endtask

    task automatic test_zero_ops;
        logic [15:0] sig0; int s0;
        @(negedge clk); @(negedge clk);
        sig0 = signature; s0 = start_cnt;
        go = 1'b1; num_ops = 8'd0;
        @(negedge clk); go = 1'b0;
        vectors++; if (done !== 1'b1 || run_busy !== 1'b0) begin miscompares++; $display("FAIL zero_done: done=%b run_busy=%b want 1 0", done, run_busy); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done_width: got %b want 0", done); end
        repeat (3) @(negedge clk);
        vectors++; if (start_cnt !== s0 || signature !== sig0) begin miscompares++; $display("FAIL zero_quiet: starts=%0d sig=%h want 0 %h", start_cnt - s0, signature, sig0); end
    endtask

    task automatic test_go_ignored;
        bit ok; int s0;
        @(negedge clk);
        busy_len = 4; s0 = start_cnt;
        go = 1'b1; num_ops = 8'd3;
        @(negedge clk); go = 1'b0;
        repeat (4) @(negedge clk);
        go = 1'b1; num_ops = 8'd1; seed_load = 1'b1; seed_in = 16'h1234;
        @(negedge clk); go = 1'b0; seed_load = 1'b0;
        ok = 1'b0;
        for (int b = 0; b < 500; b++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        model_run(3);
        vectors++; if (!ok || op_count !== 8'd3) begin miscompares++; $display("FAIL busy_go_count: got %0d want 3", op_count); end
        vectors++; if (signature !== exp_sig) begin miscompares++; $display("FAIL busy_go_sig: got %h want %h", signature, exp_sig); end
        @(negedge clk);
        vectors++; if (start_cnt - s0 !== 3) begin miscompares++; $display("FAIL busy_go_starts: got %0d want 3", start_cnt - s0); end
    endtask

    task automatic test_full_count;
        bit ok; int s0;
        @(negedge clk);
        busy_len = 1; s0 = start_cnt;
        do_run(8'd255, ok);
        model_run(255);
        vectors++; if (!ok || op_count !== 8'd255) begin miscompares++; $display("FAIL full_count: got %0d want 255", op_count); end
        vectors++; if (signature !== exp_sig) begin miscompares++; $display("FAIL full_sig: got %h want %h", signature, exp_sig); end
        @(negedge clk);
        vectors++; if (start_cnt - s0 !== 255) begin miscompares++; $display("FAIL full_starts: got %0d want 255", start_cnt - s0); end
    endtask

    task automatic test_async_reset;
        bit ok, seen;
        @(negedge clk);
        busy_len = 10;
        go = 1'b1; num_ops = 8'd2;
        @(negedge clk); go = 1'b0;
        seen = 1'b0;
        for (int b = 0; b < 20; b++) begin
            if (mult_busy) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++; if (!seen || {mult_start, done, run_busy, err_timeout} !== 4'b0000) begin miscompares++; $display("FAIL async_ctrl: got %b want 0000", {mult_start, done, run_busy, err_timeout}); end
        vectors++; if ({m_out, n_out, last_prod, signature, op_count} !== 72'h0) begin miscompares++; $display("FAIL async_data: got %h want 0", {m_out, n_out, last_prod, signature, op_count}); end
        @(negedge clk); rst = 1'b0;
        ref_lfsr = 16'hACE1;
        do_run(8'd1, ok);
        model_run(1);
        vectors++; if (!ok || m_out !== 16'hACE1 || n_out !== 16'hE270) begin miscompares++; $display("FAIL async_restart: got %h/%h want ace1/e270", m_out, n_out); end
        vectors++; if (signature !== 16'h4470) begin miscompares++; $display("FAIL async_sig: got %h want 4470", signature); end
    endtask

    initial begin
        test_reset;
        test_single_op;
        test_seed_load;
        test_multi_op;
        test_timeout;
        test_zero_ops;
        test_go_ignored;
        test_full_count;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
